// File: rtl/dw_fp_dot_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dw_fp_dot_seq: sequential FP dot product around a fused a*b+c MAC |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+

module dw_fp_dot_seq_mac #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic [sig_width+exp_width:0] a_i,
  input  logic [sig_width+exp_width:0] b_i,
  input  logic [sig_width+exp_width:0] c_i,
  input  logic [2:0]                   rnd_i,
  output logic [sig_width+exp_width:0] z_o,
  output logic [7:0]                   status_o
);
  localparam int W    = sig_width + exp_width + 1;
  localparam int M    = sig_width + 1;
  localparam int N    = 2*M + 4;
  localparam int EW   = exp_width + $clog2(N) + 3;
  localparam int BIAS = (1 << (exp_width-1)) - 1;
  localparam int EMAX = (1 << exp_width) - 1;
  localparam bit FTZ  = (ieee_compliance == 0);

  function automatic logic [M-1:0] mant(input logic [W-1:0] x);
    if (x[W-2:sig_width] == '0) return FTZ ? '0 : {1'b0, x[sig_width-1:0]};
    return {1'b1, x[sig_width-1:0]};
  endfunction

  function automatic logic signed [EW-1:0] expo(input logic [W-1:0] x);
    return (x[W-2:sig_width] == '0) ? EW'(1) : EW'(x[W-2:sig_width]);
  endfunction

  // Right shift that folds every discarded bit into the LSB as a sticky bit.
  function automatic logic [N-1:0] shr_sticky(input logic [N-1:0] v, input logic [EW-1:0] sh);
    logic [N-1:0] r;
    logic         s;
    if (sh >= EW'(N)) begin
      r = '0;
      s = |v;
    end else begin
      r = v >> sh;
      s = |(v & ~({N{1'b1}} << sh));
    end
    return {r[N-1:1], r[0] | s};
  endfunction

  logic [M-1:0]         ma, mb, mc;
  logic [2*M-1:0]       pm;
  logic                 sp, sc, za, zb, zc, ia, ib, ic, zp, ip, invalid;
  logic signed [EW-1:0] ep, ec, emax, er;
  logic [N-1:0]         opp, opc, big, sml, sum, nrm;
  logic                 sbig, ssml, rs, g, st, inc, to_inf, tiny;
  logic [exp_width-1:0] ef;
  logic [W-2:0]         pk;
  int                   lpos;

  always_comb begin
    ma = mant(a_i);
    mb = mant(b_i);
    mc = mant(c_i);
    ia = &a_i[W-2:sig_width];
    ib = &b_i[W-2:sig_width];
    ic = &c_i[W-2:sig_width];
    za = ~ia & (ma == '0);
    zb = ~ib & (mb == '0);
    zc = ~ic & (mc == '0);
    sp = a_i[W-1] ^ b_i[W-1];
    sc = c_i[W-1];
    zp = za | zb;
    ip = (ia | ib) & ~zp;
    invalid = ((ia | ib) & zp) | (ip & ic & (sp ^ sc));

    pm  = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};
    ep  = expo(a_i) + expo(b_i) - EW'(BIAS);
    ec  = expo(c_i);
    opp = {1'b0, pm, 3'b000};
    opc = {2'b00, mc, {(M-1){1'b0}}, 3'b000};

    if (zp) begin
      emax = ec;  big = opc;  sbig = sc;  sml = '0;  ssml = sc;
    end else if (zc || ep >= ec) begin
      emax = ep;  big = opp;  sbig = sp;  ssml = sc;
      sml  = zc ? '0 : shr_sticky(opc, ep - ec);
    end else begin
      emax = ec;  big = opc;  sbig = sc;  ssml = sp;
      sml  = shr_sticky(opp, ec - ep);
    end

    if (sbig != ssml && sml > big) begin
      sum = sml - big;  rs = ssml;
    end else if (sbig != ssml) begin
      sum = big - sml;  rs = sbig;
    end else begin
      sum = big + sml;  rs = sbig;
    end

    lpos = 0;
    for (int i = 0; i < N; i++) if (sum[i]) lpos = i;
    er  = emax + EW'(lpos) - EW'(2*M + 1);
    nrm = sum << (N - 1 - lpos);
    if (!FTZ && er < EW'(1)) nrm = shr_sticky(nrm, EW'(1) - er);
    ef = (er < EW'(1)) ? '0 : er[exp_width-1:0];

    g    = nrm[N-1-M];
    st   = |nrm[N-2-M:0];
    tiny = ~nrm[N-1];
    case (rnd_i)
      3'd1:    inc = 1'b0;
      3'd2:    inc = ~rs & (g | st);
      3'd3:    inc = rs & (g | st);
      3'd4:    inc = g;
      3'd5:    inc = g | st;
      default: inc = g & (st | nrm[N-M]);
    endcase
    case (rnd_i)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = ~rs;
      3'd3:    to_inf = rs;
      default: to_inf = 1'b1;
    endcase
    pk = {ef, nrm[N-2 -: sig_width]} + {{(W-2){1'b0}}, inc};

    z_o         = {rs, pk};
    status_o    = '0;
    status_o[0] = (pk == '0);
    status_o[3] = tiny;
    status_o[5] = g | st;

    if (er >= EW'(EMAX) || &pk[W-2:sig_width]) begin
      z_o      = to_inf ? {rs, {exp_width{1'b1}}, {sig_width{1'b0}}}
                        : {rs, {(exp_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
      status_o = to_inf ? 8'h32 : 8'h30;
    end
    if (FTZ && er < EW'(1)) begin
      z_o      = {rs, {(W-1){1'b0}}};
      status_o = 8'h29;
    end
    if (sum == '0) begin
      z_o      = '0;
      z_o[W-1] = (zp & zc) ? ((rnd_i == 3'd3) ? (sp | sc) : (sp & sc)) : (rnd_i == 3'd3);
      status_o = 8'h01;
    end
    if (invalid) begin
      z_o      = FTZ ? {1'b0, {exp_width{1'b1}}, {sig_width{1'b0}}}
                     : {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
      status_o = 8'h04;
    end else if (ip) begin
      z_o      = {sp, {exp_width{1'b1}}, {sig_width{1'b0}}};
      status_o = 8'h02;
    end else if (ic) begin
      z_o      = {sc, {exp_width{1'b1}}, {sig_width{1'b0}}};
      status_o = 8'h02;
    end
  end
endmodule

module dw_fp_dot_seq #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic [2:0]                   rnd_i,
  output logic                         busy_o,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [sig_width+exp_width:0] in_a_i,
  input  logic [sig_width+exp_width:0] in_b_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [sig_width+exp_width:0] out_z_o,
  output logic [7:0]                   out_status_o
);
  localparam int W = sig_width + exp_width + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         acc_q, acc_d, z_q, z_d, mac_z;
  logic [7:0]           stat_q, stat_d, ostat_q, ostat_d, mac_st;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [2:0]           rnd_q, rnd_d;

  dw_fp_dot_seq_mac #(
    .sig_width      (sig_width),
    .exp_width      (exp_width),
    .ieee_compliance(ieee_compliance)
  ) u_mac (
    .a_i     (in_a_i),
    .b_i     (in_b_i),
    .c_i     (acc_q),
    .rnd_i   (rnd_q),
    .z_o     (mac_z),
    .status_o(mac_st)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      stat_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      rnd_q   <= '0;
      z_q     <= '0;
      ostat_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rnd_q   <= rnd_d;
      z_q     <= z_d;
      ostat_q <= ostat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    stat_d      = stat_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    rnd_d       = rnd_q;
    z_d         = z_q;
    ostat_d     = ostat_q;
    busy_o      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d  = len_i;
          rnd_d  = rnd_i;
          acc_d  = '0;
          stat_d = '0;
          cnt_d  = '0;
          if (len_i == '0) begin
            z_d     = '0;
            ostat_d = 8'h01;
            state_d = S_DONE;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        busy_o     = 1'b1;
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          acc_d  = mac_z;
          stat_d = stat_q | mac_st;
          cnt_d  = cnt_q + LEN_WIDTH'(1);
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            z_d     = mac_z;
            ostat_d = stat_q | mac_st;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_z_o      = z_q;
  assign out_status_o = ostat_q;
endmodule
`default_nettype wire

// File: tb/tb_dw_fp_dot_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dw_fp_dot_seq: directed scoreboard bench for dw_fp_dot_seq     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dw_fp_dot_seq;
  localparam int W = 32;
  localparam logic [W-1:0] ONE = 32'h3F800000, TWO = 32'h40000000, HALF = 32'h3F000000;

  logic         clk = 1'b0;
  logic         rst, start, busy, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]   len, out_status;
  logic [2:0]   rnd;
  logic [W-1:0] in_a, in_b, out_z;

  typedef struct packed {
    logic [W-1:0] z;
    logic [7:0]   st;
  } exp_t;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dw_fp_dot_seq #(.sig_width(23), .exp_width(8), .ieee_compliance(0), .LEN_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .len_i       (len),
    .rnd_i       (rnd),
    .busy_o      (busy),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_z_o     (out_z),
    .out_status_o(out_status)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start_job(input int l, input int r, input bit push,
                           input logic [W-1:0] z, input logic [7:0] st);
    exp_t e;
    if (push) begin
      e.z  = z;
      e.st = st;
      sb_q.push_back(e);
    end
    start = 1'b1;
    len   = 8'(l);
    rnd   = 3'(r);
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    check("in_ready_acc", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   waitc = 0;
    while (out_valid !== 1'b1 && waitc < 1000) begin
      tick();
      waitc++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    e = sb_q.pop_front();
    check({tag, "_z"}, out_z, e.z);
    check({tag, "_status"}, 32'(out_status), 32'(e.st));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; rnd = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_in_ready",  32'(in_ready),   32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_out_z",     out_z,           32'd0);
    check("rst_status",    32'(out_status), 32'd0);

    // back-to-back job, one-cycle result latency
    start_job(3, 0, 1'b1, 32'h41700000, 8'h00);
    send_pair(ONE, TWO, 0);
    send_pair(32'h40400000, 32'h40800000, 0);
    send_pair(HALF, TWO, 0);
    check("t1_latency",  32'(out_valid), 32'd1);
    check("t1_rdy_done", 32'(in_ready),  32'd0);
    collect("t1");

    // zero-length job
    start_job(0, 0, 1'b1, 32'h0, 8'h01);
    check("t2_valid_next", 32'(out_valid), 32'd1);
    check("t2_no_ready",   32'(in_ready),  32'd0);
    collect("t2");

    // gapped input, stalled sink, start ignored while DONE
    start_job(3, 0, 1'b1, 32'h41700000, 8'h00);
    send_pair(ONE, TWO, 2);
    send_pair(32'h40400000, 32'h40800000, 2);
    send_pair(HALF, TWO, 0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = '0;
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_z",     out_z,          32'h41700000);
      check("t3_hold_rdy",   32'(in_ready),  32'd0);
      tick();
    end
    start = 1'b1;
    collect("t3");
    start = 1'b0;
    tick();
    check("t3_no_restart", 32'(busy), 32'd0);

    // overflow to infinity
    start_job(1, 0, 1'b1, 32'h7F800000, 8'h32);
    send_pair(32'h7F000000, TWO, 0);
    collect("t4");

    // reset mid-job discards the partial sum
    start_job(4, 0, 1'b0, 32'h0, 8'h00);
    send_pair(ONE, ONE, 0);
    send_pair(ONE, ONE, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy",      32'(busy),       32'd0);
    check("t5_in_ready",  32'(in_ready),   32'd0);
    check("t5_out_valid", 32'(out_valid),  32'd0);
    check("t5_out_z",     out_z,           32'd0);
    check("t5_status",    32'(out_status), 32'd0);
    start_job(1, 0, 1'b1, 32'h40800000, 8'h00);
    send_pair(TWO, TWO, 0);
    collect("t5");

    // maximum length, counter must not wrap
    start_job(255, 0, 1'b1, 32'h437F0000, 8'h00);
    for (int i = 0; i < 255; i++) send_pair(ONE, ONE, 0);
    collect("t6");

    // rounding modes and cancellation
    start_job(2, 0, 1'b1, 32'h3F800000, 8'h20);
    send_pair(ONE, ONE, 0);
    send_pair(32'h33800000, ONE, 0);
    collect("t7_rne_tie");
    start_job(2, 2, 1'b1, 32'h3F800001, 8'h20);
    send_pair(ONE, ONE, 0);
    send_pair(32'h33800000, ONE, 0);
    collect("t7_rup");
    start_job(2, 0, 1'b1, 32'h00000000, 8'h01);
    send_pair(ONE, ONE, 0);
    send_pair(32'hBF800000, ONE, 0);
    collect("t7_cancel");
    start_job(2, 0, 1'b1, HALF, 8'h00);
    send_pair(32'h3FC00000, ONE, 0);
    send_pair(32'hBF800000, ONE, 0);
    collect("t7_sub");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
